// File: rtl/fetch_pc_stage_pkg.sv
// rtl/fetch_pc_stage_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pc_stage_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_stage_pc_reg.sv
// rtl/fetch_pc_stage_pc_reg.sv - program counter with load and +4 increment
module fetch_pc_stage_pc_reg
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    // Wraps modulo 2^32 with no carry out; a redirect beats the sequential step.
    assign pc_plus4 = pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// rtl/fetch_pc_stage.sv - fetch FSM, imem request channel and decode output register
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pcplus4,
    input  logic               id_ready
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_req_addr;
    logic              req_fire;
    logic              resp_in_wait;
    logic              resp_in_drop;
    logic              load_out;
    logic              consumed;

    assign target        = word_align(redirect_pc);
    assign req_fire      = (state == FS_REQ) && imem_req_valid && imem_req_ready;
    assign resp_in_wait  = (state == FS_WAIT) && imem_resp_valid;
    assign resp_in_drop  = (state == FS_DROP) && imem_resp_valid;
    assign load_out      = resp_in_wait && !redirect_valid;
    assign consumed      = if_valid && id_ready;
    assign next_req_addr = redirect_valid ? target : pc;

    fetch_pc_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (redirect_valid),
        .load_pc  (target),
        .inc      (load_out),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    // Request outputs are registered: every entry into REQ loads the address along with
    // the state, except the very first REQ after reset, which spends one cycle idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= FS_REQ;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= '0;
        end else begin
            case (state)
                FS_REQ: begin
                    if (req_fire) begin
                        imem_req_valid <= 1'b0;
                        state          <= redirect_valid ? FS_DROP : FS_WAIT;
                    end else if (redirect_valid || !imem_req_valid) begin
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= next_req_addr;
                    end
                end
                FS_WAIT: begin
                    if (resp_in_wait && redirect_valid) begin
                        state          <= FS_REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= target;
                    end else if (resp_in_wait) begin
                        state <= FS_HOLD;
                    end else if (redirect_valid) begin
                        state <= FS_DROP;
                    end
                end
                // Only leave once the output register is free, so a response never lands
                // on an instruction decode has not taken yet.
                FS_HOLD: begin
                    if (redirect_valid || !if_valid || id_ready) begin
                        state          <= FS_REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= next_req_addr;
                    end
                end
                // The stale response retires the only outstanding request, so leave even
                // if a redirect arrives with it; otherwise DROP would wait forever.
                FS_DROP: begin
                    if (resp_in_drop) begin
                        state          <= FS_REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= next_req_addr;
                    end
                end
                default: begin
                    state          <= FS_REQ;
                    imem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            if_pcplus4 <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (load_out) begin
            if_valid   <= 1'b1;
            if_instr   <= imem_resp_data;
            if_pc      <= pc;
            if_pcplus4 <= pc_plus4;
        end else if (consumed) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb/tb_fetch_pc_stage.sv - self-checking bench for fetch_pc_stage
module tb_fetch_pc_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;
    logic        id_ready;

    always #5 clk = ~clk;

    fetch_pc_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pcplus4      (if_pcplus4),
        .id_ready        (id_ready)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_wait;
    bit          poison = 1'b0;
    int unsigned ready_pct = 100;
    int unsigned lat_extra = 0;

    logic [31:0] exp_pc = RST_PC;
    bit          stalled_prev = 1'b0;
    logic [31:0] snap_pc;
    logic [31:0] snap_instr;
    logic [31:0] dq_pc[$];
    int          dq_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: one request at a time, answers 1..1+lat_extra cycles after acceptance.
    task automatic mem_model();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (pend) begin
            if (pend_wait == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = poison ? 32'hDEAD_BEEF : mem_word(pend_addr);
                poison = 1'b0;
                pend   = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            check("one_outstanding", 32'(pend), 32'd0);
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            pend_wait = int'($urandom_range(0, lat_extra));
        end
    endtask

    // Reference: decode sees the sequential PC stream, restarted at each redirect target.
    task automatic monitor();
        if (!reset_n) begin
            exp_pc       = RST_PC;
            stalled_prev = 1'b0;
            return;
        end
        if (stalled_prev) begin
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc", if_pc, snap_pc);
            check("stall_instr", if_instr, snap_instr);
        end
        if (if_valid && !id_ready)
            check("stall_no_req", 32'(imem_req_valid), 32'd0);
        if (if_valid && id_ready) begin
            check("deliv_pc", if_pc, exp_pc);
            check("deliv_instr", if_instr, mem_word(exp_pc));
            check("deliv_pcplus4", if_pcplus4, exp_pc + 32'd4);
            dq_pc.push_back(if_pc);
            dq_cyc.push_back(cyc);
            exp_pc = exp_pc + 32'd4;
        end
        stalled_prev = if_valid && !id_ready && !redirect_valid;
        snap_pc      = if_pc;
        snap_instr   = if_instr;
        if (redirect_valid)
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
    endtask

    task automatic tick();
        mem_model();
        monitor();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_deliv(input int n, input string tag);
        int start = dq_pc.size();
        int k = 0;
        while (dq_pc.size() < start + n && k < 80) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, 32'(dq_pc.size() >= start + n), 32'd1);
    endtask

    initial begin
        int k;
        int n0;

        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        id_ready        = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // reset held three cycles
        repeat (3) tick();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_pcplus4", if_pcplus4, 32'd0);
        id_ready  = 1'b1;
        ready_pct = 100;
        lat_extra = 0;
        reset_n   = 1'b1;
        tick();
        check("rel_req_valid", 32'(imem_req_valid), 32'd1);
        check("rel_req_addr", imem_req_addr, RST_PC);

        // straight-line, 1-cycle memory
        n0 = dq_pc.size();
        wait_deliv(4, "t2");
        for (int i = 0; i < 4; i++)
            check("t2_pc", dq_pc[n0 + i], RST_PC + 32'(4 * i));
        for (int i = 1; i < 4; i++)
            check("t2_interval", 32'(dq_cyc[n0 + i] - dq_cyc[n0 + i - 1]), 32'd3);

        // back-pressure
        id_ready = 1'b0;
        k = 0;
        while (if_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("t3_got_instr", 32'(if_valid), 32'd1);
        repeat (5) tick();
        check("t3_held_valid", 32'(if_valid), 32'd1);
        check("t3_no_req", 32'(imem_req_valid), 32'd0);
        check("t3_held_pc", if_pc, exp_pc);
        id_ready = 1'b1;
        tick();
        check("t3_resume_valid", 32'(imem_req_valid), 32'd1);
        check("t3_resume_addr", imem_req_addr, exp_pc);

        // redirect in WAIT, stale response arrives in DROP
        k = 0;
        while (!pend && k < 20) begin
            tick();
            k++;
        end
        check("t4_in_wait", 32'(pend), 32'd1);
        pend_wait      = 2;
        poison         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        tick();
        redirect_valid = 1'b0;
        k = 0;
        while (imem_req_valid !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("t4_req_addr", imem_req_addr, 32'h0040_0100);
        wait_deliv(1, "t4");
        check("t4_deliv_pc", dq_pc[$], 32'h0040_0100);

        // redirect coincident with response in WAIT
        k = 0;
        while (!pend && k < 20) begin
            tick();
            k++;
        end
        check("t5a_in_wait", 32'(pend), 32'd1);
        pend_wait      = 0;
        poison         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0012_3456;
        tick();
        redirect_valid = 1'b0;
        wait_deliv(1, "t5a");
        check("t5a_deliv_pc", dq_pc[$], 32'h0012_3454);

        // redirect coincident with request handshake in REQ
        k = 0;
        while (imem_req_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("t5b_in_req", 32'(imem_req_valid), 32'd1);
        poison         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0ABC_DEF0;
        tick();
        redirect_valid = 1'b0;
        wait_deliv(1, "t5b");
        check("t5b_deliv_pc", dq_pc[$], 32'h0ABC_DEF0);

        // wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n0 = dq_pc.size();
        wait_deliv(2, "t6");
        check("t6_pc0", dq_pc[n0], 32'hFFFF_FFFC);
        check("t6_pc1", dq_pc[n0 + 1], 32'h0000_0000);

        // reset while a response is outstanding; it arrives in REQ and must be ignored
        k = 0;
        while (!pend && k < 20) begin
            tick();
            k++;
        end
        check("t7_in_wait", 32'(pend), 32'd1);
        pend_wait = 1;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("t7_if_valid", 32'(if_valid), 32'd0);
        check("t7_req_valid", 32'(imem_req_valid), 32'd1);
        check("t7_req_addr", imem_req_addr, RST_PC);
        wait_deliv(1, "t7");
        check("t7_deliv_pc", dq_pc[$], RST_PC);

        // randomized traffic against the stream model
        ready_pct = 70;
        lat_extra = 3;
        n0 = dq_pc.size();
        for (int i = 0; i < 3000; i++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check("rand_progress", 32'(dq_pc.size() >= n0 + 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
